// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_if
// Brief   : Instruction-memory req/ack bus between the fetch stage and imem.
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : PC, imem req/ack fetch, one-entry stall buffer, redirects and the
//           IF/ID register. Optional perf counters under FETCH_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   fetch_stage_if.master      imem,
   input  logic               stall,
   input  logic               beq_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  jump_target,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc_next,
   output logic [3:0]         opcode
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        perf_fetched,
   output logic [15:0]        perf_bubbles
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
   logic               buf_valid_q, buf_valid_d;
   logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
   logic [ADDR_W-1:0]  buf_pcn_q, buf_pcn_d;
   logic               ifv_q, ifv_d;
   logic [INSTR_W-1:0] ifi_q, ifi_d;
   logic [ADDR_W-1:0]  ifp_q, ifp_d;

   logic               w_req;
   logic [ADDR_W-1:0]  w_addr;
   logic               w_accept;
   logic               w_redirect;
   logic [ADDR_W-1:0]  w_pc_plus2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         buf_valid_q  <= 1'b0;
         buf_instr_q  <= '0;
         buf_pcn_q    <= '0;
         ifv_q        <= 1'b0;
         ifi_q        <= '0;
         ifp_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         buf_valid_q  <= buf_valid_d;
         buf_instr_q  <= buf_instr_d;
         buf_pcn_q    <= buf_pcn_d;
         ifv_q        <= ifv_d;
         ifi_q        <= ifi_d;
         ifp_q        <= ifp_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      buf_valid_d  = buf_valid_q;
      buf_instr_d  = buf_instr_q;
      buf_pcn_d    = buf_pcn_q;
      ifv_d        = ifv_q;
      ifi_d        = ifi_q;
      ifp_d        = ifp_q;

      // Request is held combinationally from state, so it cannot drop before ack.
      w_req      = (state_q == ST_DRAIN) || ((state_q == ST_WAIT) && !buf_valid_q);
      w_addr     = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
      w_accept   = (state_q == ST_WAIT) && w_req && imem.imem_ack;
      w_redirect = jump || beq_taken;
      w_pc_plus2 = pc_q + ADDR_W'(2);

      if (w_redirect) begin
         ifv_d       = 1'b0;
         ifi_d       = '0;
         buf_valid_d = 1'b0;
         pc_d        = jump ? jump_target : branch_target;
         if (w_req && !imem.imem_ack) begin
            state_d      = ST_DRAIN;
            drain_addr_d = w_addr;
         end else begin
            state_d = ST_WAIT;
         end
      end else begin
         if (state_q == ST_IDLE)
            state_d = ST_WAIT;
         if ((state_q == ST_DRAIN) && imem.imem_ack)
            state_d = ST_WAIT;
         if (w_accept)
            pc_d = w_pc_plus2;

         if (stall) begin
            if (w_accept) begin
               buf_valid_d = 1'b1;
               buf_instr_d = imem.imem_rdata;
               buf_pcn_d   = w_pc_plus2;
            end
         end else if (buf_valid_q) begin
            ifv_d       = 1'b1;
            ifi_d       = buf_instr_q;
            ifp_d       = buf_pcn_q;
            buf_valid_d = 1'b0;
         end else if (w_accept) begin
            ifv_d = 1'b1;
            ifi_d = imem.imem_rdata;
            ifp_d = w_pc_plus2;
         end else begin
            ifv_d = 1'b0;
            ifi_d = '0;
         end
      end
   end

   assign imem.imem_req  = w_req;
   assign imem.imem_addr = w_addr;
   assign if_id_valid    = ifv_q;
   assign if_id_instr    = ifi_q;
   assign if_id_pc_next  = ifp_q;
   assign opcode         = ifi_q[INSTR_W-1 -: 4];

`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched_q;
   logic [15:0] perf_bubbles_q;

   // A flushed IF/ID entry was never consumed, so redirects do not count it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_bubbles_q <= '0;
      end else begin
         if (ifv_q && !stall && !w_redirect && (perf_fetched_q != 16'hFFFF))
            perf_fetched_q <= perf_fetched_q + 16'd1;
         if (!ifv_q && !stall && (perf_bubbles_q != 16'hFFFF))
            perf_bubbles_q <= perf_bubbles_q + 16'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Self-checking bench for fetch_stage: directed scenarios plus a
//           randomized run against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, beq_taken = 1'b0, jump = 1'b0;
   logic [15:0] branch_target = '0, jump_target = '0;
   logic        if_id_valid;
   logic [15:0] if_id_instr, if_id_pc_next;
   logic [3:0]  opcode;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched, perf_bubbles;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) imem ();

   fetch_stage #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (imem),
      .stall         (stall),
      .beq_taken     (beq_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr),
      .if_id_pc_next (if_id_pc_next),
      .opcode        (opcode)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_bubbles  (perf_bubbles)
`endif
   );

   // memory model state and per-cycle samples
   int          lat = 0;
   int          wcnt = 0;
   bit          rand_lat = 0;
   logic        req_s, ack_s;
   logic [15:0] addr_s, rdata_s;

   // reference model state
   bit          m_idle = 1, m_drain = 0;
   logic [15:0] m_pc = '0, m_daddr = '0;
   logic [31:0] m_buf[$];
   logic        m_ifv = 0;
   logic [15:0] m_ifi = '0, m_ifp = '0;
   logic        m_req_e;
   logic [15:0] m_addr_e;
   int          m_fetched = 0, m_bubbles = 0;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h2123;
         16'h0002: return 16'h3456;
         16'h0004: return 16'h4789;
         16'h0006: return 16'h7ABC;
         default:  return (a * 16'h9E37) ^ 16'h5A3C;
      endcase
   endfunction

   task automatic model_update(input logic st, input logic bq, input logic [15:0] bt,
                               input logic jp, input logic [15:0] jt);
      logic        acc;
      logic [31:0] e;
      if (!rst_n) begin
         m_idle = 1; m_drain = 0; m_pc = '0; m_daddr = '0; m_buf.delete();
         m_ifv = 0; m_ifi = '0; m_ifp = '0; m_fetched = 0; m_bubbles = 0;
         return;
      end
      if (m_ifv && !st && !(bq || jp) && m_fetched < 65535) m_fetched++;
      if (!m_ifv && !st && m_bubbles < 65535) m_bubbles++;
      acc = m_req_e && ack_s && !m_idle && !m_drain;
      if (jp || bq) begin
         m_ifv = 0; m_ifi = '0; m_buf.delete();
         if (m_req_e && !ack_s) begin
            if (!m_drain) m_daddr = m_pc;
            m_drain = 1;
         end else begin
            m_drain = 0;
         end
         m_pc = jp ? jt : bt;
         m_idle = 0;
      end else if (m_idle) begin
         m_idle = 0;
      end else if (m_drain) begin
         if (ack_s) m_drain = 0;
      end else begin
         if (st) begin
            if (acc) m_buf.push_back({rdata_s, 16'(m_pc + 16'd2)});
         end else if (m_buf.size() != 0) begin
            e = m_buf.pop_front();
            m_ifv = 1; m_ifi = e[31:16]; m_ifp = e[15:0];
         end else if (acc) begin
            m_ifv = 1; m_ifi = rdata_s; m_ifp = 16'(m_pc + 16'd2);
         end else begin
            m_ifv = 0; m_ifi = '0;
         end
         if (acc) m_pc = 16'(m_pc + 16'd2);
      end
   endtask

   // One clock: drive inputs, answer the request, clock, advance the model.
   task automatic step(input logic st, input logic bq, input logic [15:0] bt,
                       input logic jp, input logic [15:0] jt);
      stall = st; beq_taken = bq; branch_target = bt; jump = jp; jump_target = jt;
      #1;
      req_s  = imem.imem_req;
      addr_s = imem.imem_addr;
      ack_s  = 1'b0;
      if (req_s) begin
         if (wcnt >= lat) begin
            ack_s = 1'b1;
            wcnt  = 0;
            if (rand_lat) lat = $urandom_range(0, 2);
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
      rdata_s = mem_word(addr_s);
      imem.imem_ack   = ack_s;
      imem.imem_rdata = rdata_s;
      m_req_e  = !m_idle && (m_drain || m_buf.size() == 0);
      m_addr_e = m_drain ? m_daddr : m_pc;
      @(posedge clk);
      #1;
      model_update(st, bq, bt, jp, jt);
      imem.imem_ack = 1'b0;
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wcnt  = 0;
      idle_step();
      idle_step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      idle_step();
      checks++; if (req_s !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req_s); end
      checks++; if (addr_s !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", addr_s); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
      checks++; if (if_id_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", if_id_instr); end
      checks++; if (if_id_pc_next !== 16'h0000) begin errors++; $display("FAIL reset_pcn got %h want 0000", if_id_pc_next); end
      checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode got %h want 0", opcode); end
      rst_n = 1'b1;
   endtask

   task automatic test_zero_wait();
      logic [15:0] exp_i [3] = '{16'h2123, 16'h3456, 16'h4789};
      do_reset();
      lat = 0;
      idle_step();
      checks++; if (req_s !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", req_s); end
      for (int i = 0; i < 3; i++) begin
         idle_step();
         checks++; if (req_s !== 1'b1 || addr_s !== 16'(2 * i)) begin
            errors++; $display("FAIL zw_addr[%0d] got req=%b addr=%h want req=1 addr=%h", i, req_s, addr_s, 16'(2 * i));
         end
         checks++; if (if_id_valid !== 1'b1 || if_id_instr !== exp_i[i] || if_id_pc_next !== 16'(2 * i + 2)) begin
            errors++; $display("FAIL zw_ifid[%0d] got v=%b i=%h p=%h want v=1 i=%h p=%h",
                               i, if_id_valid, if_id_instr, if_id_pc_next, exp_i[i], 16'(2 * i + 2));
         end
      end
      checks++; if (opcode !== 4'h4) begin errors++; $display("FAIL zw_opcode got %h want 4", opcode); end
   endtask

   task automatic test_slow_mem();
      logic        pend = 1'b0;
      logic [15:0] pa = '0;
      int          acks = 0;
      do_reset();
      lat = 3;
      idle_step();
      for (int i = 0; i < 16; i++) begin
         idle_step();
         if (pend) begin
            checks++; if (req_s !== 1'b1 || addr_s !== pa) begin
               errors++; $display("FAIL slow_hold[%0d] got req=%b addr=%h want req=1 addr=%h", i, req_s, addr_s, pa);
            end
         end
         checks++; if (if_id_valid !== ack_s) begin
            errors++; $display("FAIL slow_load[%0d] got valid=%b want %b", i, if_id_valid, ack_s);
         end
         if (ack_s) begin
            acks++;
            checks++; if (if_id_instr !== mem_word(addr_s)) begin
               errors++; $display("FAIL slow_instr[%0d] got %h want %h", i, if_id_instr, mem_word(addr_s));
            end
         end
         pend = req_s && !ack_s;
         pa   = addr_s;
      end
      checks++; if (acks != 4) begin errors++; $display("FAIL slow_acks got %0d want 4", acks); end
   endtask

   task automatic test_stall_buffer();
      do_reset();
      lat = 0;
      idle_step();
      repeat (3) idle_step();
      step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
      checks++; if (ack_s !== 1'b1 || addr_s !== 16'h0006) begin
         errors++; $display("FAIL stall_ack got ack=%b addr=%h want ack=1 addr=0006", ack_s, addr_s);
      end
      checks++; if (if_id_instr !== 16'h4789) begin errors++; $display("FAIL stall_hold got %h want 4789", if_id_instr); end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
         checks++; if (req_s !== 1'b0 || if_id_instr !== 16'h4789) begin
            errors++; $display("FAIL stall_full[%0d] got req=%b instr=%h want req=0 instr=4789", i, req_s, if_id_instr);
         end
      end
      idle_step();
      checks++; if (req_s !== 1'b0) begin errors++; $display("FAIL drain_req got %b want 0", req_s); end
      checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'h7ABC || if_id_pc_next !== 16'h0008) begin
         errors++; $display("FAIL drain_ifid got v=%b i=%h p=%h want v=1 i=7abc p=0008", if_id_valid, if_id_instr, if_id_pc_next);
      end
      idle_step();
      checks++; if (req_s !== 1'b1 || addr_s !== 16'h0008) begin
         errors++; $display("FAIL after_drain got req=%b addr=%h want req=1 addr=0008", req_s, addr_s);
      end
   endtask

   task automatic test_redirect_drain();
      bit drained = 0, got = 0;
      do_reset();
      lat = 3;
      idle_step();
      idle_step();
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0040);
      checks++; if (ack_s !== 1'b0 || if_id_valid !== 1'b0) begin
         errors++; $display("FAIL jmp_pending got ack=%b valid=%b want ack=0 valid=0", ack_s, if_id_valid);
      end
      for (int i = 0; i < 20 && !got; i++) begin
         idle_step();
         if (!drained) begin
            checks++; if (req_s !== 1'b1 || addr_s !== 16'h0000 || if_id_valid !== 1'b0) begin
               errors++; $display("FAIL drain[%0d] got req=%b addr=%h valid=%b want req=1 addr=0000 valid=0",
                                  i, req_s, addr_s, if_id_valid);
            end
            if (ack_s) drained = 1;
         end else begin
            checks++; if (req_s !== 1'b1 || addr_s !== 16'h0040) begin
               errors++; $display("FAIL tgt_req[%0d] got req=%b addr=%h want req=1 addr=0040", i, req_s, addr_s);
            end
            checks++; if (if_id_valid !== ack_s) begin
               errors++; $display("FAIL tgt_valid[%0d] got %b want %b", i, if_id_valid, ack_s);
            end
            if (ack_s) begin
               got = 1;
               checks++; if (if_id_instr !== mem_word(16'h0040) || if_id_pc_next !== 16'h0042) begin
                  errors++; $display("FAIL tgt_ifid got i=%h p=%h want i=%h p=0042", if_id_instr, if_id_pc_next, mem_word(16'h0040));
               end
            end
         end
      end
      checks++; if (!got) begin errors++; $display("FAIL tgt_timeout got no target fetch want one within 20 cycles"); end
   endtask

   task automatic test_jump_priority();
      do_reset();
      lat = 0;
      idle_step();
      idle_step();
      idle_step();
      step(1'b1, 1'b1, 16'h0100, 1'b1, 16'h0200);
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 || opcode !== 4'h0) begin
         errors++; $display("FAIL prio_flush got v=%b i=%h op=%h want v=0 i=0000 op=0", if_id_valid, if_id_instr, opcode);
      end
      idle_step();
      checks++; if (req_s !== 1'b1 || addr_s !== 16'h0200) begin
         errors++; $display("FAIL prio_addr got req=%b addr=%h want req=1 addr=0200", req_s, addr_s);
      end
      checks++; if (if_id_instr !== mem_word(16'h0200) || if_id_pc_next !== 16'h0202) begin
         errors++; $display("FAIL prio_ifid got i=%h p=%h want i=%h p=0202", if_id_instr, if_id_pc_next, mem_word(16'h0200));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      lat = 0;
      idle_step();
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFC);
      idle_step();
      checks++; if (addr_s !== 16'hFFFC) begin errors++; $display("FAIL wrap_a got %h want fffc", addr_s); end
      idle_step();
      checks++; if (addr_s !== 16'hFFFE || if_id_pc_next !== 16'h0000) begin
         errors++; $display("FAIL wrap_b got addr=%h pcn=%h want addr=fffe pcn=0000", addr_s, if_id_pc_next);
      end
      idle_step();
      checks++; if (addr_s !== 16'h0000 || req_s !== 1'b1) begin
         errors++; $display("FAIL wrap_c got req=%b addr=%h want req=1 addr=0000", req_s, addr_s);
      end
   endtask

   task automatic test_reset_midfetch();
      do_reset();
      lat = 3;
      idle_step();
      idle_step();
      idle_step();
      rst_n = 1'b0;
      #1;
      checks++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== 16'h0000 || if_id_valid !== 1'b0) begin
         errors++; $display("FAIL midreset got req=%b addr=%h valid=%b want 0/0000/0",
                            imem.imem_req, imem.imem_addr, if_id_valid);
      end
      wcnt = 0;
      idle_step();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic        st, bq, jp;
      logic [15:0] bt, jt;
      do_reset();
      rand_lat = 1;
      lat = 1;
      for (int i = 0; i < 600; i++) begin
         st = ($urandom_range(0, 99) < 30);
         bq = ($urandom_range(0, 99) < 6);
         jp = ($urandom_range(0, 99) < 5);
         bt = 16'($urandom) & 16'hFFFE;
         jt = 16'($urandom) & 16'hFFFE;
         step(st, bq, bt, jp, jt);
         checks++; if (req_s !== m_req_e || (m_req_e && addr_s !== m_addr_e)) begin
            errors++; $display("FAIL rnd_req[%0d] got req=%b addr=%h want req=%b addr=%h", i, req_s, addr_s, m_req_e, m_addr_e);
         end
         checks++; if (if_id_valid !== m_ifv || if_id_instr !== m_ifi || opcode !== m_ifi[15:12]) begin
            errors++; $display("FAIL rnd_ifid[%0d] got v=%b i=%h op=%h want v=%b i=%h", i, if_id_valid, if_id_instr, opcode, m_ifv, m_ifi);
         end
         if (m_ifv) begin
            checks++; if (if_id_pc_next !== m_ifp) begin
               errors++; $display("FAIL rnd_pcn[%0d] got %h want %h", i, if_id_pc_next, m_ifp);
            end
         end
`ifdef FETCH_PERF_EN
         checks++; if (perf_fetched !== 16'(m_fetched) || perf_bubbles !== 16'(m_bubbles)) begin
            errors++; $display("FAIL rnd_perf[%0d] got f=%0d b=%0d want f=%0d b=%0d", i, perf_fetched, perf_bubbles, m_fetched, m_bubbles);
         end
`endif
      end
      rand_lat = 0;
   endtask

   initial begin
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = '0;
      #2;
      test_reset();
      test_zero_wait();
      test_slow_mem();
      test_stall_buffer();
      test_redirect_drain();
      test_jump_priority();
      test_wrap();
      test_reset_midfetch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
